// File: rtl/csr_file_if.sv
// CSR entry type, internal CSR index map, and the read/write access interface of csr_file.
// The optional counter logic in csr_file is enabled by defining CSR_HW_COUNTERS_EN.
typedef union packed {
  logic [63:0] raw;
  struct packed {
    logic [1:0]  mxl;
    logic [35:0] zero;
    logic [25:0] ext;
  } misa;
} csr_reg_u;

localparam int unsigned CSR_IDX_MISA          = 1;
localparam int unsigned CSR_IDX_MCOUNTINHIBIT = 2;
localparam int unsigned CSR_IDX_MCYCLE        = 3;
localparam int unsigned CSR_IDX_MINSTRET      = 4;
localparam int unsigned CSR_IDX_STIMECMP      = 5;

interface csr_file_if #(
  parameter int IDX_W = 8
);
  logic [IDX_W-1:0] rd_idx;
  csr_reg_u         rd_data;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  csr_reg_u         wr_data;

  modport master (output rd_idx, wr_en, wr_idx, wr_data, input rd_data);
  modport slave  (input rd_idx, wr_en, wr_idx, wr_data, output rd_data);
endinterface

// File: rtl/csr_file.sv
// CSR storage with a post-reset initialisation walk, supervisor timer compare and,
// when CSR_HW_COUNTERS_EN is defined, hardware MCYCLE/MINSTRET counting.
module csr_file #(
  parameter int N_CSR = 256,
  parameter int IDX_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  csr_file_if.slave         bus,
  input  csr_reg_u          csr_regs_init [N_CSR],
  input  logic              instret_inc,
  input  logic [63:0]       time_i,
  output logic              ready,
  output logic              stip
);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e           r_state;
  state_e           w_state_next;
  logic [IDX_W-1:0] r_cnt;
  csr_reg_u         r_entries [N_CSR];
  logic             r_stip;
  logic             w_run;

  assign w_run = (r_state == ST_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_INIT;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (r_state == ST_INIT && r_cnt == IDX_W'(N_CSR - 1)) w_state_next = ST_RUN;
  end

  always_comb begin
    ready       = 1'b0;
    bus.rd_data = '0;
    stip        = r_stip;
    if (w_run) begin
      ready       = 1'b1;
      bus.rd_data = r_entries[bus.rd_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_cnt <= '0;
    else if (r_state == ST_INIT) r_cnt <= r_cnt + 1'b1;
  end

`ifdef CSR_HW_COUNTERS_EN
  logic w_cy_en;
  logic w_ir_en;
  // Inhibit bits come from the stored register, so a same-cycle write to it does not apply yet.
  assign w_cy_en = ~r_entries[CSR_IDX_MCOUNTINHIBIT].raw[0];
  assign w_ir_en = instret_inc & ~r_entries[CSR_IDX_MCOUNTINHIBIT].raw[2];
`else
  logic w_unused_instret;
  assign w_unused_instret = instret_inc;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CSR; i++) r_entries[i] <= '0;
    end else if (!w_run) begin
      r_entries[r_cnt] <= csr_regs_init[r_cnt];
    end else begin
`ifdef CSR_HW_COUNTERS_EN
      if (w_cy_en) r_entries[CSR_IDX_MCYCLE].raw   <= r_entries[CSR_IDX_MCYCLE].raw + 64'd1;
      if (w_ir_en) r_entries[CSR_IDX_MINSTRET].raw <= r_entries[CSR_IDX_MINSTRET].raw + 64'd1;
`endif
      // Placed last so a software write overrides a same-cycle increment.
      if (bus.wr_en) r_entries[bus.wr_idx] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_stip <= 1'b0;
    else        r_stip <= w_run && (time_i >= r_entries[CSR_IDX_STIMECMP].raw);
  end

endmodule

// File: tb/tb_csr_file.sv
// Randomised self-checking bench for csr_file against an array-based behavioural model,
// plus directed walk, timer-compare and counter scenarios.
module tb_csr_file;
  localparam int N = 256;
  localparam logic [63:0] MISA_INIT = 64'h8000_0000_0000_1001;
  localparam logic [63:0] ONES      = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  csr_reg_u    init_vals [N];
  logic        instret_inc;
  logic [63:0] time_i;
  logic        ready;
  logic        stip;

  always #5 clk = ~clk;

  csr_file_if #(.IDX_W(8)) bus_if ();

  csr_file #(.N_CSR(N), .IDX_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus_if.slave),
    .csr_regs_init (init_vals),
    .instret_inc   (instret_inc),
    .time_i        (time_i),
    .ready         (ready),
    .stip          (stip)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] m_mem [N];
  bit          m_run;
  int          m_cnt;
  bit          m_stip;
  int          hot [5] = '{CSR_IDX_MISA, CSR_IDX_MCOUNTINHIBIT, CSR_IDX_MCYCLE,
                           CSR_IDX_MINSTRET, CSR_IDX_STIMECMP};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_run  = 1'b0;
    m_cnt  = 0;
    m_stip = 1'b0;
    for (int i = 0; i < N; i++) m_mem[i] = '0;
  endtask

  // Advance one clock: update the model from the inputs seen at the edge, then step the DUT.
  task automatic cycle();
    logic [63:0] inh;
    if (!m_run) begin
      m_mem[m_cnt] = init_vals[m_cnt].raw;
      m_stip = 1'b0;
      if (m_cnt == N - 1) m_run = 1'b1;
      m_cnt++;
    end else begin
      m_stip = (time_i >= m_mem[CSR_IDX_STIMECMP]);
      inh = m_mem[CSR_IDX_MCOUNTINHIBIT];
`ifdef CSR_HW_COUNTERS_EN
      if (!inh[0]) m_mem[CSR_IDX_MCYCLE] = m_mem[CSR_IDX_MCYCLE] + 64'd1;
      if (instret_inc && !inh[2]) m_mem[CSR_IDX_MINSTRET] = m_mem[CSR_IDX_MINSTRET] + 64'd1;
`endif
      if (bus_if.wr_en) m_mem[bus_if.wr_idx] = bus_if.wr_data.raw;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_rd"}, bus_if.rd_data.raw, m_run ? m_mem[bus_if.rd_idx] : 64'd0);
    check({tag, "_stip"}, {63'd0, stip}, {63'd0, m_stip});
    check({tag, "_ready"}, {63'd0, ready}, {63'd0, m_run});
  endtask

  task automatic idle_inputs();
    bus_if.wr_en   = 1'b0;
    bus_if.wr_idx  = '0;
    bus_if.wr_data = '0;
    bus_if.rd_idx  = '0;
    instret_inc    = 1'b0;
  endtask

  task automatic write_csr(input int idx, input logic [63:0] data);
    bus_if.wr_en       = 1'b1;
    bus_if.wr_idx      = 8'(idx);
    bus_if.wr_data.raw = data;
    $display("WR idx=%0d data=%h", idx, data);
    cycle();
    bus_if.wr_en = 1'b0;
  endtask

  // Walk from reset release: ready must be low for 255 edges and high from edge 256.
  task automatic walk_check(input string tag);
    for (int c = 1; c <= N; c++) begin
      bus_if.rd_idx      = (c % 2 == 0) ? 8'(CSR_IDX_MISA) : 8'($urandom_range(0, N - 1));
      bus_if.wr_en       = $urandom_range(0, 1) == 1;
      bus_if.wr_idx      = 8'($urandom_range(0, N - 1));
      bus_if.wr_data.raw = {$urandom, $urandom};
      instret_inc        = $urandom_range(0, 1) == 1;
      #1;
      check({tag, "_init_rd"}, bus_if.rd_data.raw, 64'd0);
      check({tag, "_init_stip"}, {63'd0, stip}, 64'd0);
      cycle();
      check({tag, "_ready_walk"}, {63'd0, ready}, {63'd0, c >= N});
    end
    idle_inputs();
    $display("WALK %s done, ready=%0b", tag, ready);
  endtask

  task automatic sweep_check(input string tag);
    logic [63:0] exp;
    for (int i = 0; i < N; i++) begin
      bus_if.rd_idx = 8'(i);
      #1;
      exp = init_vals[i].raw;
`ifdef CSR_HW_COUNTERS_EN
      if (i == CSR_IDX_MCYCLE || i == CSR_IDX_MINSTRET) exp = m_mem[i];
`endif
      check({tag, "_entry"}, bus_if.rd_data.raw, exp);
      cycle();
    end
    bus_if.rd_idx = 8'(CSR_IDX_MISA);
    #1;
    check({tag, "_misa"}, bus_if.rd_data.raw, MISA_INIT);
    $display("SWEEP %s done", tag);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("reset_ready", {63'd0, ready}, 64'd0);
    check("reset_stip", {63'd0, stip}, 64'd0);
    check("reset_rd", bus_if.rd_data.raw, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int idx;
    for (int i = 0; i < N; i++) init_vals[i].raw = {$urandom, $urandom};
    init_vals[CSR_IDX_MISA].raw          = MISA_INIT;
    init_vals[CSR_IDX_STIMECMP].raw      = ONES;
    init_vals[CSR_IDX_MCOUNTINHIBIT].raw = '0;
    idle_inputs();
    time_i = '0;

    apply_reset();
    walk_check("walk1");
    sweep_check("sweep1");

    // Random RUN traffic, including same-cycle read-of-written-index and init changes.
    for (int n = 0; n < 2000; n++) begin
      bus_if.wr_en       = $urandom_range(0, 2) == 0;
      idx                = ($urandom_range(0, 1) == 1) ? hot[$urandom_range(0, 4)]
                                                       : int'($urandom_range(0, N - 1));
      bus_if.wr_idx      = 8'(idx);
      bus_if.wr_data.raw = {$urandom, $urandom};
      bus_if.rd_idx      = ($urandom_range(0, 3) == 0) ? bus_if.wr_idx
                                                       : 8'($urandom_range(0, N - 1));
      instret_inc        = $urandom_range(0, 1) == 1;
      time_i             = {$urandom, $urandom};
      if ($urandom_range(0, 9) == 0) begin
        idx = int'($urandom_range(6, N - 1));
        init_vals[idx].raw = {$urandom, $urandom};
      end
      #1;
      check_outputs("rand");
      if (bus_if.wr_en) $display("RND WR idx=%0d data=%h", bus_if.wr_idx, bus_if.wr_data.raw);
      cycle();
    end
    idle_inputs();
    time_i = '0;

    // Timer compare boundaries.
    time_i = 64'd999;
    write_csr(CSR_IDX_STIMECMP, 64'd1000);
    cycle();
    check("stip_999", {63'd0, stip}, 64'd0);
    time_i = 64'd1000;
    cycle();
    check("stip_1000", {63'd0, stip}, 64'd1);
    write_csr(CSR_IDX_STIMECMP, ONES);
    check("stip_old_cmp", {63'd0, stip}, 64'd1);
    cycle();
    check("stip_ones", {63'd0, stip}, 64'd0);
    time_i = ONES - 64'd1;
    cycle();
    check("stip_max_m1", {63'd0, stip}, 64'd0);
    time_i = ONES;
    cycle();
    check("stip_max", {63'd0, stip}, 64'd1);
    time_i = '0;
    cycle();

`ifdef CSR_HW_COUNTERS_EN
    write_csr(CSR_IDX_MCOUNTINHIBIT, 64'd0);
    bus_if.rd_idx = 8'(CSR_IDX_MCYCLE);
    write_csr(CSR_IDX_MCYCLE, ONES - 64'd1);
    check("mcycle_fe", bus_if.rd_data.raw, ONES - 64'd1);
    cycle();
    check("mcycle_ff", bus_if.rd_data.raw, ONES);
    cycle();
    check("mcycle_wrap", bus_if.rd_data.raw, 64'd0);
    write_csr(CSR_IDX_MCOUNTINHIBIT, 64'd1);
    check("mcycle_last_inc", bus_if.rd_data.raw, 64'd1);
    cycle();
    cycle();
    check("mcycle_frozen", bus_if.rd_data.raw, 64'd1);

    bus_if.rd_idx = 8'(CSR_IDX_MINSTRET);
    instret_inc = 1'b1;
    write_csr(CSR_IDX_MINSTRET, 64'd5);
    check("minstret_wr_wins", bus_if.rd_data.raw, 64'd5);
    for (int k = 0; k < 3; k++) cycle();
    instret_inc = 1'b0;
    cycle();
    check("minstret_8", bus_if.rd_data.raw, 64'd8);
    write_csr(CSR_IDX_MCOUNTINHIBIT, 64'd4);
    instret_inc = 1'b1;
    cycle();
    cycle();
    instret_inc = 1'b0;
    check("minstret_inhibit", bus_if.rd_data.raw, 64'd8);
`else
    write_csr(CSR_IDX_MCYCLE, 64'h1234);
    write_csr(CSR_IDX_MINSTRET, 64'h5678);
    instret_inc = 1'b1;
    for (int k = 0; k < 50; k++) cycle();
    instret_inc = 1'b0;
    bus_if.rd_idx = 8'(CSR_IDX_MCYCLE);
    #1;
    check("mcycle_plain", bus_if.rd_data.raw, 64'h1234);
    bus_if.rd_idx = 8'(CSR_IDX_MINSTRET);
    #1;
    check("minstret_plain", bus_if.rd_data.raw, 64'h5678);
    cycle();
`endif

    // Reset from RUN after writes, then again mid-walk at cycle 100.
    write_csr(CSR_IDX_MISA, 64'hDEAD_BEEF);
    apply_reset();
    for (int k = 0; k < 100; k++) cycle();
    check("mid_walk_ready", {63'd0, ready}, 64'd0);
    apply_reset();
    walk_check("walk2");
    sweep_check("sweep2");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/csr_file.md
CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 The block SHALL have parameter N_CSR, default 256, meaning the number of internal CSR entries.
REQ-002 The block SHALL have parameter IDX_W, default 8, meaning the internal index width (log2 N_CSR).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port csr_regs_init, input, csr_reg_u[N_CSR]: per-entry init values, driven by CSRInit.
REQ-006 The block SHALL have port rd_idx, input, IDX_W bits: read internal index.
REQ-007 The block SHALL have port rd_data, output, csr_reg_u: read data.
REQ-008 The block SHALL have port wr_en, input, 1 bit: write strobe.
REQ-009 The block SHALL have port wr_idx, input, IDX_W bits: write internal index.
REQ-010 The block SHALL have port wr_data, input, csr_reg_u: write data.
REQ-011 The block SHALL have port instret_inc, input, 1 bit: one instruction retired this cycle.
REQ-012 The block SHALL have port time_i, input, 64 bits: current platform time.
REQ-013 The block SHALL have port ready, output, 1 bit: the initialisation walk is complete.
REQ-014 The block SHALL have port stip, output, 1 bit: supervisor timer interrupt pending.

Function
REQ-015 The FSM SHALL have states INIT and RUN; reset enters INIT with walk counter = 0.
REQ-016 In INIT, each cycle SHALL copy csr_regs_init[cnt] into entry cnt and increment cnt.
REQ-017 When cnt = N_CSR-1 is copied, the next state SHALL be RUN, so ready asserts exactly N_CSR cycles after reset deassertion.
REQ-018 In INIT, wr_en and instret_inc SHALL be ignored, rd_data SHALL be 0, and stip SHALL be 0.
REQ-019 In RUN, rd_data SHALL be combinational: entry[rd_idx]; a same-cycle write to rd_idx SHALL NOT be forwarded (old value returned).
REQ-020 In RUN, wr_en=1 SHALL write wr_data to entry[wr_idx] at the next edge, full 64 bits with no field masking.
REQ-021 RUN is terminal; the only way back to INIT is assertion of rst_n.
REQ-022 stip SHALL be registered: in RUN, next stip = (time_i >= entry[internal_idx(STIMECMP)]), unsigned 64-bit compare, so it has 1-cycle latency.
REQ-023 With the all-ones stimecmp init value, stip SHALL remain 0 for every time_i < 2^64-1.
REQ-024 A write to STIMECMP SHALL affect stip from the cycle after the write commits (2 edges after wr_en).

Reset
REQ-025 On rst_n low, asynchronously: state=INIT, cnt=0, ready=0, stip=0, all entries=0.
REQ-026 Reset asserted mid-INIT SHALL restart the walk from entry 0.
REQ-027 Reset asserted in RUN SHALL discard all written values; values are reloaded from csr_regs_init.
REQ-028 csr_regs_init SHALL be sampled only during INIT; changes in RUN have no effect.

Configuration
REQ-029 Macro CSR_HW_COUNTERS_EN SHALL control hardware counting of MCYCLE and MINSTRET.
REQ-030 With CSR_HW_COUNTERS_EN defined, in RUN, MCYCLE SHALL increment by 1 each cycle unless MCOUNTINHIBIT.CY (bit 0) = 1.
REQ-031 With CSR_HW_COUNTERS_EN defined, MINSTRET SHALL increment by 1 when instret_inc=1, unless MCOUNTINHIBIT.IR (bit 2) = 1.
REQ-032 Both counters SHALL wrap from 2^64-1 to 0.
REQ-033 A software write to a counter in the same cycle as an increment SHALL win, storing wr_data unincremented.
REQ-034 The inhibit bits SHALL be read from the current stored MCOUNTINHIBIT, not from a same-cycle write.
REQ-035 Without CSR_HW_COUNTERS_EN, MCYCLE and MINSTRET SHALL be plain storage, instret_inc SHALL be unused, and no counter logic is synthesised.

Verification
REQ-036 Release rst_n, sample ready each cycle -> ready=0 for 255 cycles and 1 from cycle 256; rd MISA during INIT returns 0, and in RUN returns the init value (MXL=2, A=1, M=1).
REQ-037 Pulse rst_n low at walk cycle 100 -> ready rises 256 cycles after the second release, and all entries equal init values.
REQ-038 Write STIMECMP=1000 with time_i=999 -> stip=0; with time_i=1000 -> stip=1 one cycle later; then write STIMECMP=all-ones -> stip=0 two edges after wr_en.
REQ-039 CSR_HW_COUNTERS_EN on: write MCYCLE=2^64-2 -> reads show ...FE, ...FF, then 0; write MCOUNTINHIBIT=1 -> MCYCLE freezes.
REQ-040 CSR_HW_COUNTERS_EN on: instret_inc=1 with a same-cycle write MINSTRET=5 -> MINSTRET reads 5; three further pulses -> 8.
REQ-041 CSR_HW_COUNTERS_EN off: run 50 cycles with instret_inc=1 -> MCYCLE and MINSTRET keep their written values.
